// File: rtl/hex_segment_pkg.sv
// Shared constants, state type and pattern decoder for the seven-segment hex decoder.
// Segment codes are active-low with bit6..0 = a..g.
package hex_segment_pkg;

  // Entry n holds the active-low pattern shown for hex value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  localparam logic [6:0]  SEG_MARK_OK   = 7'h3F;
  localparam logic [6:0]  SEG_BLANK     = 7'h7F;
  localparam logic [13:0] BLANK_PATTERN = {SEG_BLANK, SEG_BLANK};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] hex;
  } dec_result_t;

  // A hit needs the valid marker together with a digit found in the table.
  function automatic dec_result_t decode_pattern(input logic [6:0] mark,
                                                 input logic [6:0] digit);
    dec_result_t res;
    res = '0;
    if (mark == SEG_MARK_OK) begin
      for (int i = 0; i < 16; i++) begin
        if (digit == SEG_TABLE[i]) begin
          res.hit = 1'b1;
          res.hex = 4'(i);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_segment_decoder_filter.sv
// Sample register and stability counter: flags a pattern once it has been seen
// STABLE_CYCLES times in a row.
module seg_stability_filter
  import hex_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] din,
  output logic [13:0] sample,
  output logic        stable
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Saturating at STABLE_CYCLES makes the stable pulse fire only once per run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= BLANK_PATTERN;
      cnt    <= '0;
    end else begin
      sample <= din;
      if (din != sample) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable = (cnt == CNT_STABLE);

endmodule

// File: rtl/hex_segment_decoder.sv
// Decodes stable active-low seven-segment patterns into hex/one-hot results.
// Optional macro HEXDEC_ERRCNT_EN adds a saturating err_count output.
module hex_segment_decoder
  import hex_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_digit,
  input  logic [6:0]  seg_mark,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_hex,
  output logic [15:0] out_onehot,
  output logic        out_err,
  output logic        overrun
`ifdef HEXDEC_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  logic [13:0] sample;
  logic        stable;
  logic [13:0] pend_pat;
  logic [13:0] last_pat;
  dec_state_t  state;
  dec_result_t dec;
  logic        is_blank;
  logic        out_full;
  logic        load;
  logic        drop;

  seg_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .din    ({seg_mark, seg_digit}),
    .sample (sample),
    .stable (stable)
  );

  assign is_blank = (sample == BLANK_PATTERN);
  assign dec      = decode_pattern(pend_pat[13:7], pend_pat[6:0]);
  assign out_full = out_valid && !out_ready;
  assign load     = (state == EMIT) && !out_full;
  assign drop     = (state == EMIT) && out_full;

  // last_pat remembers what was emitted (or dropped) so a held pattern is not repeated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_pat <= BLANK_PATTERN;
      last_pat <= BLANK_PATTERN;
    end else begin
      case (state)
        IDLE: begin
          if (stable) begin
            if (is_blank) begin
              last_pat <= BLANK_PATTERN;
            end else if (sample != last_pat) begin
              pend_pat <= sample;
              last_pat <= sample;
              state    <= EMIT;
            end
          end
        end
        EMIT: state <= HOLD;
        HOLD: begin
          if (sample != last_pat) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load on the handshake edge keeps out_valid high with the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_hex    <= '0;
      out_onehot <= '0;
      out_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_hex    <= dec.hit ? dec.hex : 4'h0;
        out_onehot <= dec.hit ? (16'h0001 << dec.hex) : 16'h0000;
        out_err    <= !dec.hit;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef HEXDEC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if ((state == EMIT) && !dec.hit && (err_count != 8'hFF)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Directed self-checking bench for hex_segment_decoder with STABLE_CYCLES=4.
module tb_hex_segment_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_digit;
  logic [6:0]  seg_mark;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_hex;
  logic [15:0] out_onehot;
  logic        out_err;
  logic        overrun;
`ifdef HEXDEC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [6:0] codes [16];

  hex_segment_decoder #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_digit  (seg_digit),
    .seg_mark   (seg_mark),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hex    (out_hex),
    .out_onehot (out_onehot),
    .out_err    (out_err),
    .overrun    (overrun)
`ifdef HEXDEC_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [6:0] mark, input logic [6:0] digit);
    seg_mark  = mark;
    seg_digit = digit;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for out_valid and checks latency in edges plus the result fields.
  task automatic expect_result(input string tag, input logic [3:0] hex, input logic err,
                               input int latency);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check_output({tag, "_latency"}, 32'(n), 32'(latency));
    check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_output({tag, "_hex"}, 32'(out_hex), 32'(err ? 4'h0 : hex));
    check_output({tag, "_onehot"}, 32'(out_onehot), err ? 32'h0 : (32'h1 << hex));
    check_output({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  task automatic hold_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (out_valid) seen++;
    end
    check_output(tag, 32'(seen), 32'd0);
  endtask

  task automatic blank_gap(input string tag);
    apply_stimulus(7'h7F, 7'h7F);
    hold_quiet(tag, 6);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    codes = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    rst       = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(7'h7F, 7'h7F);
    repeat (3) tick();
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_hex", 32'(out_hex), 32'd0);
    check_output("reset_onehot", 32'(out_onehot), 32'd0);
    check_output("reset_err", 32'(out_err), 32'd0);
    check_output("reset_overrun", 32'(overrun), 32'd0);
`ifdef HEXDEC_ERRCNT_EN
    check_output("reset_err_count", 32'(err_count), 32'd0);
`endif
    rst = 1'b0;
    hold_quiet("blank_after_reset", 8);

    // Digit 2 emitted once, as a single-cycle pulse, then silence while held.
    apply_stimulus(7'h3F, 7'h12);
    expect_result("digit2", 4'h2, 1'b0, 6);
    tick();
    check_output("digit2_pulse_width", 32'(out_valid), 32'd0);
    hold_quiet("digit2_no_repeat", 12);

    // Full table sweep with blank separators.
    for (int i = 0; i < 16; i++) begin
      blank_gap($sformatf("sweep_blank_%0d", i));
      apply_stimulus(7'h3F, codes[i]);
      expect_result($sformatf("sweep_%0d", i), 4'(i), 1'b0, 6);
    end

    // Unrecognised digit with the valid marker, then a good digit with a bad marker.
    blank_gap("err_blank_a");
    apply_stimulus(7'h3F, 7'h7E);
    expect_result("bad_digit", 4'h0, 1'b1, 6);
`ifdef HEXDEC_ERRCNT_EN
    check_output("err_count_1", 32'(err_count), 32'd1);
`endif
    blank_gap("err_blank_b");
    apply_stimulus(7'h7F, 7'h12);
    expect_result("bad_marker", 4'h0, 1'b1, 6);
`ifdef HEXDEC_ERRCNT_EN
    check_output("err_count_2", 32'(err_count), 32'd2);
`endif

    // Short 3 then stable 4: only 4 comes out.
    blank_gap("glitch_blank");
    apply_stimulus(7'h3F, 7'h06);
    repeat (3) tick();
    check_output("glitch_no_output", 32'(out_valid), 32'd0);
    apply_stimulus(7'h3F, 7'h4C);
    expect_result("glitch_then_4", 4'h4, 1'b0, 6);

    // Overrun: 5 held un-accepted, 9 arrives and is dropped.
    blank_gap("overrun_blank");
    check_output("overrun_before", 32'(overrun), 32'd0);
    out_ready = 1'b0;
    apply_stimulus(7'h3F, 7'h24);
    expect_result("hold_5", 4'h5, 1'b0, 6);
    apply_stimulus(7'h3F, 7'h04);
    repeat (8) tick();
    check_output("overrun_valid_held", 32'(out_valid), 32'd1);
    check_output("overrun_hex_held", 32'(out_hex), 32'd5);
    check_output("overrun_onehot_held", 32'(out_onehot), 32'h0020);
    check_output("overrun_set", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    tick();
    check_output("overrun_consumed", 32'(out_valid), 32'd0);
    hold_quiet("overrun_no_9", 10);
    check_output("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while 7 is pending, then 7 again after release.
    blank_gap("reset_blank");
    out_ready = 1'b0;
    apply_stimulus(7'h3F, 7'h0F);
    expect_result("seven", 4'h7, 1'b0, 6);
    rst = 1'b1;
    tick();
    check_output("midreset_valid", 32'(out_valid), 32'd0);
    check_output("midreset_hex", 32'(out_hex), 32'd0);
    check_output("midreset_onehot", 32'(out_onehot), 32'd0);
    check_output("midreset_err", 32'(out_err), 32'd0);
    check_output("midreset_overrun", 32'(overrun), 32'd0);
`ifdef HEXDEC_ERRCNT_EN
    check_output("midreset_err_count", 32'(err_count), 32'd0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;
    expect_result("seven_again", 4'h7, 1'b0, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
